// File: rtl/apb_timer_slave_pkg.sv
// Shared definitions for the APB timer slave: register offsets, CTRL bit
// positions, bus FSM encoding and the offset decoder.
package apb_timer_slave_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [11:0] OFF_CTRL   = 12'h000;
  localparam logic [11:0] OFF_LOAD   = 12'h004;
  localparam logic [11:0] OFF_COUNT  = 12'h008;
  localparam logic [11:0] OFF_STATUS = 12'h00C;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_RELOAD_BIT = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT = 2;
  localparam int unsigned CTRL_W          = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } bus_state_e;

  typedef enum logic [2:0] {
    SEL_CTRL   = 3'd0,
    SEL_LOAD   = 3'd1,
    SEL_COUNT  = 3'd2,
    SEL_STATUS = 3'd3,
    SEL_NONE   = 3'd4
  } reg_sel_e;

  // Misaligned offsets never match a register, so they fall into SEL_NONE.
  function automatic reg_sel_e decode_offset(input logic [11:0] off);
    case (off)
      OFF_CTRL:   return SEL_CTRL;
      OFF_LOAD:   return SEL_LOAD;
      OFF_COUNT:  return SEL_COUNT;
      OFF_STATUS: return SEL_STATUS;
      default:    return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/apb_timer_slave_core.sv
// Timer datapath: CTRL/LOAD/COUNT/STATUS registers, down-count, expiry and
// auto-reload, updated by write strobes decoded in the APB front end.
module apb_timer_core
  import apb_timer_slave_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctrl_wr,
  input  logic              load_wr,
  input  logic              status_wr,
  input  logic [DATA_W-1:0] wdata,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] load,
  output logic [DATA_W-1:0] count,
  output logic              expired,
  output logic              irq
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] load_q, load_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              expired_q, expired_d;
  logic              hw_expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      load_q    <= '0;
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  // Later assignments win: bus writes override the hardware count/EN update,
  // and a hardware expiry overrides a same-cycle W1C.
  always_comb begin
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    count_d   = count_q;
    expired_d = expired_q;
    hw_expire = ctrl_q[CTRL_EN_BIT] && (count_q == '0);

    if (ctrl_q[CTRL_EN_BIT]) begin
      if (hw_expire) begin
        if (ctrl_q[CTRL_RELOAD_BIT]) begin
          count_d = load_q;
        end else begin
          ctrl_d[CTRL_EN_BIT] = 1'b0;
        end
      end else begin
        count_d = count_q - 32'd1;
      end
    end

    if (status_wr && wdata[0]) begin
      expired_d = 1'b0;
    end
    if (hw_expire) begin
      expired_d = 1'b1;
    end

    if (load_wr) begin
      load_d  = wdata;
      count_d = wdata;
    end
    if (ctrl_wr) begin
      ctrl_d = wdata[CTRL_W-1:0];
    end
  end

  assign ctrl    = ctrl_q;
  assign load    = load_q;
  assign count   = count_q;
  assign expired = expired_q;
  assign irq     = expired_q && ctrl_q[CTRL_IRQ_EN_BIT];

endmodule

// File: rtl/apb_timer_slave.sv
// APB responder for the down-counting timer: setup/access FSM with
// programmable wait states, offset decode, error response and read mux.
module apb_timer_slave
  import apb_timer_slave_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
)
(
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        IRQ
);

  localparam logic [3:0] WAIT_INIT = WAIT_STATES[3:0];

  bus_state_e        state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  reg_sel_e          sel_q, sel_d;
  logic              write_q, write_d;

  logic              in_access;
  logic              ready;
  logic              bad_access;
  logic              commit;
  logic              ctrl_wr, load_wr, status_wr;
  logic [CTRL_W-1:0] ctrl_reg;
  logic [DATA_W-1:0] load_reg, count_reg, rdata;
  logic              expired;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^PADDR[31:12];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      sel_q   <= SEL_NONE;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      sel_q   <= sel_d;
      write_q <= write_d;
    end
  end

  // PENABLE is high on the completing cycle, so the next setup phase is
  // always picked up from IDLE; back-to-back transfers keep the 2-cycle rate.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    sel_d   = sel_q;
    write_d = write_q;
    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ST_SETUP;
          wait_d  = WAIT_INIT;
          sel_d   = decode_offset(PADDR[11:0]);
          write_d = PWRITE;
        end
      end
      ST_SETUP, ST_ACCESS: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else if (PENABLE) begin
          if (wait_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            wait_d  = wait_q - 4'd1;
            state_d = ST_ACCESS;
          end
        end else if (state_q == ST_ACCESS) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_access  = (state_q != ST_IDLE) && PSEL && PENABLE;
  assign ready      = in_access && (wait_q == '0);
  assign bad_access = (sel_q == SEL_NONE) || ((sel_q == SEL_COUNT) && write_q);
  assign commit     = ready && write_q && !bad_access;
  assign ctrl_wr    = commit && (sel_q == SEL_CTRL);
  assign load_wr    = commit && (sel_q == SEL_LOAD);
  assign status_wr  = commit && (sel_q == SEL_STATUS);

  always_comb begin
    rdata = '0;
    case (sel_q)
      SEL_CTRL:   rdata = {{(DATA_W-CTRL_W){1'b0}}, ctrl_reg};
      SEL_LOAD:   rdata = load_reg;
      SEL_COUNT:  rdata = count_reg;
      SEL_STATUS: rdata = {{(DATA_W-1){1'b0}}, expired};
      default:    rdata = '0;
    endcase
  end

  assign PREADY  = ready;
  assign PSLVERR = ready && bad_access;
  assign PRDATA  = (ready && !write_q && !bad_access) ? rdata : '0;

  apb_timer_core u_core (
    .clk       (PCLK),
    .rst_n     (PRESETn),
    .ctrl_wr   (ctrl_wr),
    .load_wr   (load_wr),
    .status_wr (status_wr),
    .wdata     (PWDATA),
    .ctrl      (ctrl_reg),
    .load      (load_reg),
    .count     (count_reg),
    .expired   (expired),
    .irq       (IRQ)
  );

endmodule

// File: doc/apb_timer_slave.md
# apb_timer_slave

APB responder implementing a 32-bit down-counting timer with auto-reload and interrupt, for attachment to the bridge as a third slave alongside the GPIO and UART slaves. It decodes the standard APB setup/access phases, inserts a programmable number of wait states, and flags illegal accesses on PSLVERR. Address-range selection (PSEL) is done upstream; this block decodes only the low offset bits.

## Interface
- WAIT_STATES, 1, access-phase cycles with PREADY low before completion (0..15)
- PCLK  in  1  single clock, all state on rising edge
- PRESETn  in  1  asynchronous active-low reset
- PSEL  in  1  slave select from bridge
- PENABLE  in  1  access-phase indicator
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  32  byte address; only PADDR[11:0] decoded
- PWDATA  in  32  write data
- PRDATA  out  32  read data, valid while PREADY=1 on a read
- PREADY  out  1  transfer completion
- PSLVERR  out  1  error response, valid while PREADY=1
- IRQ  out  1  level interrupt = STATUS.EXPIRED & CTRL.IRQ_EN

## Operation
- Register map (offset, access):
  - 0x000 CTRL rw: bit0 EN, bit1 RELOAD, bit2 IRQ_EN; other bits read 0.
  - 0x004 LOAD rw 32-bit; a write also copies PWDATA into COUNT.
  - 0x008 COUNT ro; a write returns PSLVERR=1, no state change.
  - 0x00C STATUS: bit0 EXPIRED; write-1-to-clear.
  - Any other offset, or PADDR[1:0]!=0: PSLVERR=1, PRDATA=0, no state change.
- Bus FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when PSEL=1 & PENABLE=0; wait counter loaded with WAIT_STATES, address/decode captured.
  - SETUP -> ACCESS when PSEL=1 & PENABLE=1.
  - ACCESS: counter decrements each cycle; PREADY=1 when counter==0. On completion -> SETUP if PSEL=1 & PENABLE=0, else IDLE.
  - PSEL=0 in any state -> IDLE; an aborted transfer commits nothing.
- Writes commit on the rising edge ending the PREADY=1 cycle; reads sample registers in that same cycle.
- Counter: when EN=1, COUNT decrements by 1 per PCLK. In the cycle COUNT==0 with EN=1: EXPIRED set; if RELOAD, COUNT<=LOAD, else EN cleared and COUNT holds 0.
- Simultaneous events: hardware set of EXPIRED beats a W1C clear in the same cycle; a LOAD write beats the decrement/reload in the same cycle; a CTRL write beats the hardware EN clear.
- Arithmetic is 32-bit unsigned; COUNT never wraps below 0.

## Timing
- Reset values: PRDATA=0, PREADY=0, PSLVERR=0, IRQ=0, CTRL=0, LOAD=0, COUNT=0, STATUS=0, FSM=IDLE.
- PREADY, PSLVERR and PRDATA are 0 outside the completing ACCESS cycle.
- Transfer latency: setup cycle + (WAIT_STATES+1) access cycles; WAIT_STATES=0 gives the 2-cycle APB minimum.
- IRQ rises one cycle after the edge where COUNT==0 is observed (EXPIRED registered).
- Reset asserted mid-transfer or mid-count: everything returns to reset values immediately; no partial commit.

## Structure
- Shared package: register offset constants (CTRL/LOAD/COUNT/STATUS), CTRL bit positions, FSM state encoding.
- One sub-module natural: apb_timer_core (COUNT/EXPIRED/reload logic, driven by decoded write strobes); the APB FSM and decode live in apb_timer_slave.

## Test plan
- WAIT_STATES=2: write LOAD=0x0000_0005 -> PREADY high on the 3rd access cycle, PSLVERR=0; read COUNT returns 5.
- CTRL=0x5 (EN, IRQ_EN) after LOAD=3 -> COUNT 3,2,1,0, EXPIRED=1, IRQ=1 next cycle, EN cleared; write STATUS=0x1 -> IRQ=0.
- CTRL=0x3 with LOAD=2 -> COUNT 2,1,0,2,1,0...; EXPIRED remains set; W1C coinciding with COUNT==0 leaves EXPIRED=1.
- Write COUNT=0x1234 and read offset 0x010 -> both complete with PSLVERR=1, COUNT unchanged, PRDATA=0.
- PSEL dropped after setup of a LOAD write -> FSM IDLE, LOAD unchanged, PREADY never asserted.
- PRESETn pulsed low while COUNT=0x100 and an access is in wait states -> all outputs 0 asynchronously, COUNT=0 after release.
